// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//
// Loadable 4-digit BCD down-counter (0000-9999) with start/pause control and
// a one-cycle terminal-count pulse. A prescaler divides i_clk so that the
// count drops by one every CLK_DIV clock edges while running.
//
// Parameters
//   CLK_DIV  i_clk edges per decrement (>= 2)
//   DIV_W    prescaler width, 2**DIV_W >= CLK_DIV
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_load                       load i_ld_* (digits > 9 clamp to 9), go IDLE
//   i_ld_units .. i_ld_thousands load value, one BCD digit each
//   i_start                      start from IDLE / resume from PAUSE (level)
//   i_pause                      freeze counting while RUN
//   o_units .. o_thousands       current BCD value
//   o_running                    high while in RUN
//   o_zero                       high when the value is 0000
//   o_done                       one-cycle pulse when counting reaches 0000
//
// Per-edge priority: i_rst > i_load > i_pause > i_start > count.
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
    parameter int CLK_DIV = 10000000,
    parameter int DIV_W   = 24
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [3:0] i_ld_units,
    input  logic [3:0] i_ld_tens,
    input  logic [3:0] i_ld_hundreds,
    input  logic [3:0] i_ld_thousands,
    input  logic       i_start,
    input  logic       i_pause,
    output logic [3:0] o_units,
    output logic [3:0] o_tens,
    output logic [3:0] o_hundreds,
    output logic [3:0] o_thousands,
    output logic       o_running,
    output logic       o_zero,
    output logic       o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);

    // Load values above 9 are not valid BCD; saturate them at 9.
    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [3:0]       units_q, units_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       hund_q, hund_d;
    logic [3:0]       thou_q, thou_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    // -----------------------------------------------------------------------
    // Decrement-by-one borrow chain. A digit steps down only when every
    // lower digit is 0; a 0 digit that steps down becomes 9.
    // -----------------------------------------------------------------------
    logic       borrow_t, borrow_h, borrow_k;
    logic [3:0] units_dec, tens_dec, hund_dec, thou_dec;
    logic       dec_reaches_zero;

    always_comb begin
        borrow_t  = (units_q == 4'd0);
        borrow_h  = borrow_t && (tens_q == 4'd0);
        borrow_k  = borrow_h && (hund_q == 4'd0);

        units_dec = (units_q == 4'd0) ? 4'd9 : units_q - 4'd1;
        tens_dec  = tens_q;
        hund_dec  = hund_q;
        thou_dec  = thou_q;
        if (borrow_t) tens_dec = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
        if (borrow_h) hund_dec = (hund_q == 4'd0) ? 4'd9 : hund_q - 4'd1;
        if (borrow_k) thou_dec = (thou_q == 4'd0) ? 4'd9 : thou_q - 4'd1;

        // RUN is never entered at 0000, so the only way the decrement lands
        // on zero is from 0001; no wrap to 9999 can occur.
        dec_reaches_zero = (units_dec == 4'd0) && (tens_dec == 4'd0) &&
                           (hund_dec == 4'd0) && (thou_dec == 4'd0);
    end

    logic is_zero;
    assign is_zero = (units_q == 4'd0) && (tens_q == 4'd0) &&
                     (hund_q == 4'd0) && (thou_q == 4'd0);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        units_d = units_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        thou_d  = thou_q;
        done_d  = 1'b0;

        if (i_load) begin
            units_d = clamp9(i_ld_units);
            tens_d  = clamp9(i_ld_tens);
            hund_d  = clamp9(i_ld_hundreds);
            thou_d  = clamp9(i_ld_thousands);
            presc_d = '0;
            state_d = S_IDLE;
        end else if (i_pause) begin
            // Prescaler and digits hold; pause also blocks start this edge.
            if (state_q == S_RUN) state_d = S_PAUSE;
        end else if (i_start && state_q == S_IDLE) begin
            if (!is_zero) begin
                state_d = S_RUN;
                presc_d = '0;
            end
        end else if (i_start && state_q == S_PAUSE) begin
            // Resume keeps the partial prescaler count.
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                units_d = units_dec;
                tens_d  = tens_dec;
                hund_d  = hund_dec;
                thou_d  = thou_dec;
                if (dec_reaches_zero) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end

        running_d = (state_d == S_RUN);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            units_q   <= 4'd0;
            tens_q    <= 4'd0;
            hund_q    <= 4'd0;
            thou_q    <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            units_q   <= units_d;
            tens_q    <= tens_d;
            hund_q    <= hund_d;
            thou_q    <= thou_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign o_units     = units_q;
    assign o_tens      = tens_q;
    assign o_hundreds  = hund_q;
    assign o_thousands = thou_q;
    assign o_running   = running_q;
    assign o_zero      = is_zero;
    assign o_done      = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

    localparam int CLK_DIV = 4;
    localparam int DIV_W   = 3;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_load = 1'b0;
    logic [3:0] i_ld_units = 4'd0, i_ld_tens = 4'd0;
    logic [3:0] i_ld_hundreds = 4'd0, i_ld_thousands = 4'd0;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic [3:0] o_units, o_tens, o_hundreds, o_thousands;
    logic       o_running, o_zero, o_done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    bcd_countdown_timer #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load),
        .i_ld_units(i_ld_units), .i_ld_tens(i_ld_tens),
        .i_ld_hundreds(i_ld_hundreds), .i_ld_thousands(i_ld_thousands),
        .i_start(i_start), .i_pause(i_pause),
        .o_units(o_units), .o_tens(o_tens), .o_hundreds(o_hundreds),
        .o_thousands(o_thousands), .o_running(o_running),
        .o_zero(o_zero), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Behavioural model: value as a plain integer, mode 0=idle 1=run 2=pause
    // ------------------------------------------------------------------
    int m_val = 0, m_presc = 0, m_mode = 0;
    bit m_done = 1'b0;

    function automatic int clampd(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    always @(posedge i_clk) begin
        m_done = 1'b0;
        if (i_rst) begin
            m_val = 0; m_presc = 0; m_mode = 0;
        end else if (i_load) begin
            m_val = clampd(i_ld_thousands) * 1000 + clampd(i_ld_hundreds) * 100 +
                    clampd(i_ld_tens) * 10 + clampd(i_ld_units);
            m_presc = 0; m_mode = 0;
        end else if (i_pause) begin
            if (m_mode == 1) m_mode = 2;
        end else if (i_start && m_mode == 0) begin
            if (m_val != 0) begin m_mode = 1; m_presc = 0; end
        end else if (i_start && m_mode == 2) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_presc == CLK_DIV - 1) begin
                m_presc = 0;
                m_val = m_val - 1;
                if (m_val == 0) begin m_mode = 0; m_done = 1'b1; end
            end else begin
                m_presc = m_presc + 1;
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    logic [15:0] dut_val;
    assign dut_val = {o_thousands, o_hundreds, o_tens, o_units};

    // Cycle-by-cycle compare against the model
    always @(negedge i_clk) begin
        if (chk_en) begin
            tests++;
            if ({dut_val, o_running, o_zero, o_done} !==
                {to_bcd(m_val), (m_mode == 1), (m_val == 0), m_done}) begin
                fails++;
                $display("FAIL cycle t=%0t: got val=%h run=%b zero=%b done=%b, want val=%h run=%b zero=%b done=%b",
                         $time, dut_val, o_running, o_zero, o_done,
                         to_bcd(m_val), (m_mode == 1), (m_val == 0), m_done);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // {value, running, zero, done}
    function automatic logic [18:0] outs();
        return {dut_val, o_running, o_zero, o_done};
    endfunction

    task automatic load(input logic [15:0] v);
        {i_ld_thousands, i_ld_hundreds, i_ld_tens, i_ld_units} = v;
        i_load = 1'b1; tick(1); i_load = 1'b0;
    endtask

    task automatic start_pulse();
        i_start = 1'b1; tick(1); i_start = 1'b0;
    endtask

    initial begin
        tick(2);
        i_rst = 1'b0;
        chk_en = 1'b1;
        chk("reset", outs(), {16'h0000, 1'b0, 1'b1, 1'b0});

        // Basic run from 0012
        load(16'h0012);
        chk("load12", outs(), {16'h0012, 1'b0, 1'b0, 1'b0});
        start_pulse();                         // E0
        chk("start12", outs(), {16'h0012, 1'b1, 1'b0, 1'b0});
        tick(3);
        chk("e3_12", outs(), {16'h0012, 1'b1, 1'b0, 1'b0});
        tick(1);
        chk("e4_11", outs(), {16'h0011, 1'b1, 1'b0, 1'b0});
        tick(43);
        chk("e47_01", outs(), {16'h0001, 1'b1, 1'b0, 1'b0});
        tick(1);
        chk("e48_done", outs(), {16'h0000, 1'b0, 1'b1, 1'b1});
        tick(1);
        chk("e49_nodone", outs(), {16'h0000, 1'b0, 1'b1, 1'b0});
        i_start = 1'b1; tick(3); i_start = 1'b0;
        chk("start_held_zero", outs(), {16'h0000, 1'b0, 1'b1, 1'b0});

        // Borrow chain
        load(16'h1000); start_pulse(); tick(4);
        chk("borrow1000", outs(), {16'h0999, 1'b1, 1'b0, 1'b0});
        load(16'h0100); start_pulse(); tick(4);
        chk("borrow0100", outs(), {16'h0099, 1'b1, 1'b0, 1'b0});

        // Pause / resume
        load(16'h0005); start_pulse(); tick(4);
        chk("p_e4", outs(), {16'h0004, 1'b1, 1'b0, 1'b0});
        tick(1);
        i_pause = 1'b1; tick(1); i_pause = 1'b0;  // E6, prescaler held at 1
        chk("paused", outs(), {16'h0004, 1'b0, 1'b0, 1'b0});
        tick(20);
        chk("pause_hold", outs(), {16'h0004, 1'b0, 1'b0, 1'b0});
        start_pulse();                          // Er
        tick(2);
        chk("resume_er2", outs(), {16'h0004, 1'b1, 1'b0, 1'b0});
        tick(1);
        chk("resume_er3", outs(), {16'h0003, 1'b1, 1'b0, 1'b0});

        // Zero start ignored, clamp
        load(16'h0000);
        i_start = 1'b1; tick(4); i_start = 1'b0;
        chk("zero_start", outs(), {16'h0000, 1'b0, 1'b1, 1'b0});
        load(16'hABCF);
        chk("clamp", outs(), {16'h9999, 1'b0, 1'b0, 1'b0});

        // Priority: pause+start in RUN -> PAUSE; load during RUN
        start_pulse(); tick(2);
        i_pause = 1'b1; i_start = 1'b1; tick(1); i_pause = 1'b0; i_start = 1'b0;
        chk("pause_over_start", outs(), {16'h9999, 1'b0, 1'b0, 1'b0});
        i_pause = 1'b1; i_start = 1'b1; tick(2); i_pause = 1'b0; i_start = 1'b0;
        chk("pause_stays", outs(), {16'h9999, 1'b0, 1'b0, 1'b0});
        start_pulse(); tick(5);
        chk("resumed9998", outs(), {16'h9998, 1'b1, 1'b0, 1'b0});
        load(16'h0042);
        chk("load_in_run", outs(), {16'h0042, 1'b0, 1'b0, 1'b0});

        // Reset mid-run
        load(16'h0037); start_pulse(); tick(2);
        chk("pre_rst", outs(), {16'h0037, 1'b1, 1'b0, 1'b0});
        i_rst = 1'b1; tick(1); i_rst = 1'b0;
        chk("rst_mid_run", outs(), {16'h0000, 1'b0, 1'b1, 1'b0});
        tick(3);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
